// File: rtl/st7735_pkg.sv
// Shared constants for the ST7735 panel bring-up logic: ROM entry layout,
// op-codes and the sequencer state encoding.
package st7735_pkg;

  localparam int ROM_W = 10;

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_LOW  = 3'd1;
  localparam logic [2:0] ST_RST_WAIT = 3'd2;
  localparam logic [2:0] ST_FETCH    = 3'd3;
  localparam logic [2:0] ST_DECODE   = 3'd4;
  localparam logic [2:0] ST_SEND     = 3'd5;
  localparam logic [2:0] ST_DELAY    = 3'd6;
  localparam logic [2:0] ST_FIN      = 3'd7;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] payload;
  } rom_entry_t;

endpackage

// File: rtl/st7735_tick_gen.sv
// Microsecond / millisecond tick generator; clear restarts both periods so
// the first tick lands one full period after clear is released.
module st7735_tick_gen #(
  parameter int CLOCK_SPEED_MHZ = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic us_tick,
  output logic ms_tick
);

  localparam int              US_W    = (CLOCK_SPEED_MHZ > 1) ? $clog2(CLOCK_SPEED_MHZ) : 1;
  localparam logic [US_W-1:0] US_LAST = US_W'(CLOCK_SPEED_MHZ - 1);
  localparam logic [9:0]      MS_LAST = 10'd999;

  logic [US_W-1:0] us_cnt_q, us_cnt_d;
  logic [9:0]      ms_cnt_q, ms_cnt_d;

  assign us_tick = (us_cnt_q == US_LAST);
  assign ms_tick = us_tick && (ms_cnt_q == MS_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    us_cnt_d = us_cnt_q + 1'b1;
    ms_cnt_d = ms_cnt_q;
    if (clear) begin
      us_cnt_d = '0;
      ms_cnt_d = '0;
    end else if (us_tick) begin
      us_cnt_d = '0;
      ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      us_cnt_q <= us_cnt_d;
      ms_cnt_q <= ms_cnt_d;
    end
  end

endmodule

// File: rtl/st7735_init_sequencer.sv
// Walks the panel init ROM: reset pulse, then command/data bytes and ms delays
// over a valid/ready byte interface, until an end marker raises DONE.
module st7735_init_sequencer
  import st7735_pkg::*;
#(
  parameter int CLOCK_SPEED_MHZ = 12,
  parameter int ROM_ADDR_W      = 6,
  parameter int RST_LOW_US      = 10,
  parameter int RST_WAIT_MS     = 120
) (
  input  logic                  SYSTEM_CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  output logic [ROM_ADDR_W-1:0] ROM_ADDR,
  input  logic [ROM_W-1:0]      ROM_DATA,
  output logic [7:0]            TX_BYTE,
  output logic                  TX_DC,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  LCD_RESET,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [15:0]           RST_LOW_LAST  = 16'(RST_LOW_US - 1);
  localparam logic [15:0]           RST_WAIT_LAST = 16'(RST_WAIT_MS - 1);
  localparam logic [ROM_ADDR_W-1:0] ADDR_LAST     = '1;

  logic [2:0]            state_q, state_d;
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_dc_q, tx_dc_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  lcd_reset_q, lcd_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;

  rom_entry_t entry;
  logic       advance;
  logic       us_tick;
  logic       ms_tick;
  logic       tick_clear;

  assign entry = ROM_DATA;

  // Periods restart on every state change, including the one into the new state.
  assign tick_clear = (state_d != state_q);

  st7735_tick_gen #(
    .CLOCK_SPEED_MHZ(CLOCK_SPEED_MHZ)
  ) u_tick_gen (
    .clk    (SYSTEM_CLK),
    .rst_n  (RESET_N),
    .clear  (tick_clear),
    .us_tick(us_tick),
    .ms_tick(ms_tick)
  );

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    tx_byte_d   = tx_byte_q;
    tx_dc_d     = tx_dc_q;
    tx_valid_d  = tx_valid_q;
    lcd_reset_d = lcd_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cnt_d       = cnt_q;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_RST_LOW;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          rom_addr_d  = '0;
          lcd_reset_d = 1'b0;
          cnt_d       = '0;
        end
      end
      ST_RST_LOW: begin
        if (us_tick) begin
          if (cnt_q == RST_LOW_LAST) begin
            state_d     = ST_RST_WAIT;
            lcd_reset_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RST_WAIT: begin
        if (ms_tick) begin
          if (cnt_q == RST_WAIT_LAST) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (entry.op)
          OP_CMD, OP_DATA: begin
            tx_byte_d  = entry.payload;
            tx_dc_d    = (entry.op == OP_DATA);
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
          end
          OP_DELAY: begin
            if (entry.payload == 8'd0) begin
              advance = 1'b1;
            end else begin
              cnt_d   = {8'd0, entry.payload};
              state_d = ST_DELAY;
            end
          end
          default: state_d = ST_FIN;
        endcase
      end
      ST_SEND: begin
        if (TX_READY) begin
          tx_valid_d = 1'b0;
          advance    = 1'b1;
        end
      end
      ST_DELAY: begin
        if (ms_tick) begin
          if (cnt_q == 16'd1) begin
            cnt_d   = '0;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The last ROM slot is terminal even without an end marker; the address never wraps.
    if (advance) begin
      if (rom_addr_q == ADDR_LAST) begin
        state_d = ST_FIN;
      end else begin
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = ST_FETCH;
      end
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      tx_byte_q   <= '0;
      tx_dc_q     <= 1'b0;
      tx_valid_q  <= 1'b0;
      lcd_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      tx_byte_q   <= tx_byte_d;
      tx_dc_q     <= tx_dc_d;
      tx_valid_q  <= tx_valid_d;
      lcd_reset_q <= lcd_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ROM_ADDR  = rom_addr_q;
  assign TX_BYTE   = tx_byte_q;
  assign TX_DC     = tx_dc_q;
  assign TX_VALID  = tx_valid_q;
  assign LCD_RESET = lcd_reset_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: doc/st7735_init_sequencer.md
# st7735_init_sequencer

Walks a small initialisation ROM and drives the ST7735 panel's power-up sequence:
- hardware reset pulse, then command bytes, parameter bytes and millisecond delays, until an end marker.
- Sits between the top level and the byte-level SPI transmitter; issues one byte at a time over a valid/ready handshake together with its DC bit.
- Raises DONE so the pixel-streaming logic can take over the transmitter.

## Interface
- CLOCK_SPEED_MHZ, 12, SYSTEM_CLK frequency in MHz; integer ≥1, sets the µs prescaler.
- ROM_ADDR_W, 6, ROM address width; depth = 2**ROM_ADDR_W.
- RST_LOW_US, 10, LCD_RESET low time in µs.
- RST_WAIT_MS, 120, wait after LCD_RESET release before the first ROM fetch.

Ports:
- SYSTEM_CLK  in  1  system clock; one clock domain.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begins the sequence.
- ROM_ADDR  out  ROM_ADDR_W  ROM read address.
- ROM_DATA  in  10  {op[1:0], payload[7:0]}; synchronous ROM, valid 1 cycle after ROM_ADDR.
- TX_BYTE  out  8  byte to the SPI transmitter.
- TX_DC  out  1  0 = command, 1 = data.
- TX_VALID  out  1  byte offered.
- TX_READY  in  1  transmitter accepts.
- LCD_RESET  out  1  panel reset, active low.
- BUSY  out  1  high from START acceptance until DONE.
- DONE  out  1  sticky high after the end marker.

## Operation
ROM ops:
- 00: command byte, DC=0.
- 01: data byte, DC=1.
- 10: delay of payload ms.
- 11: end.

States: IDLE, RST_LOW, RST_WAIT, FETCH, DECODE, SEND, DELAY, FIN.
- IDLE: on START go to RST_LOW; BUSY=1, DONE=0, ROM_ADDR=0.
- RST_LOW: LCD_RESET=0 for RST_LOW_US µs ticks, then RST_WAIT with LCD_RESET=1.
- RST_WAIT: RST_WAIT_MS ms ticks, then FETCH.
- FETCH: one cycle covering ROM latency.
- DECODE: samples ROM_DATA.
  - op 00/01: load TX_BYTE and TX_DC, set TX_VALID, go to SEND.
  - op 10 with payload 0: increment address, go to FETCH.
  - op 10 with payload ≥1: load the ms counter, go to DELAY.
  - op 11: go to FIN.
- SEND: hold TX_VALID, TX_BYTE and TX_DC stable until TX_READY is sampled high. In that cycle clear TX_VALID, increment ROM_ADDR, go to FETCH.
- DELAY: decrement on each ms tick; at 0 increment ROM_ADDR, go to FETCH.
- FIN: BUSY=0, DONE=1, go to IDLE; DONE stays high.
- Address wrap: if the entry at ROM_ADDR = 2**ROM_ADDR_W−1 is not an end marker, it is executed and then treated as end (go to FIN); no address wrap.
- START is ignored while BUSY=1. START with DONE=1 restarts the full sequence, including the reset pulse, and clears DONE.
- Tick generator:
  - µs tick: one pulse every CLOCK_SPEED_MHZ cycles.
  - ms tick: one pulse every 1000 µs ticks.
  - Both counters are cleared on every state entry, so the first tick lands a full period after entry.

## Timing
- Reset values (async, RESET_N low): TX_VALID=0, TX_BYTE=0, TX_DC=0, ROM_ADDR=0, LCD_RESET=1, BUSY=0, DONE=0, state=IDLE, all counters 0.
- Reset mid-operation: TX_VALID drops immediately, without waiting for the handshake. After release the block sits in IDLE until START.
- START sampled high in cycle n → BUSY=1 and LCD_RESET=0 in cycle n+1.
- LCD_RESET low duration: RST_LOW_US×CLOCK_SPEED_MHZ cycles, ±1.
- Entering FETCH in cycle f → TX_VALID high in cycle f+2.
- Handshake in cycle h → next TX_VALID no earlier than h+3, so there is at least one idle cycle between bytes.
- TX_READY high before TX_VALID is ignored. The byte transfers only on TX_VALID & TX_READY at a rising edge.
- DELAY of k ms → k×1000×CLOCK_SPEED_MHZ cycles, +0/+1.
- End marker in DECODE at cycle e → DONE=1 and BUSY=0 at e+2.

## Structure
- Package st7735_pkg:
  - Op-code constants: OP_CMD, OP_DATA, OP_DELAY, OP_END.
  - State encoding, 3 bits.
  - ROM entry width, 10.
- Sub-module st7735_tick_gen: inputs clear and CLOCK_SPEED_MHZ; outputs us_tick and ms_tick. Shared later with the frame-rate timer.
- The ROM is outside this block; the top level instantiates it with the init table.

## Test plan
- Reset/idle: RESET_N low mid-SEND with TX_READY held 0 → TX_VALID falls in the same cycle; all outputs at reset values; START needed to resume.
- Basic sequence: ROM {00_11, 10_78, 00_29, 11_xx}, CLOCK_SPEED_MHZ=12, TX_READY=1 → all of:
  - LCD_RESET low for 120 cycles.
  - 120 ms wait.
  - Byte 0x11 sent with DC=0, then a 120 ms gap.
  - Byte 0x29 sent with DC=0.
  - DONE=1, BUSY=0.
- Backpressure: ROM {00_2A, 01_00, 01_7F, 11}; TX_READY low for 5 cycles on each byte → TX_BYTE and TX_DC stable while TX_VALID is high; bytes arrive in order 2A/0, 00/1, 7F/1.
- Zero delay and no end marker: ROM_ADDR_W=2, ROM {10_00, 00_01, 01_02, 01_03} → the delay is skipped in 2 cycles; three bytes sent; DONE after address 3.
- Restart: START pulsed while BUSY → ignored, with no change to ROM_ADDR. START after DONE → DONE clears and LCD_RESET pulses low again.
- Timing checks: assert f→TX_VALID = 2 cycles and handshake→next TX_VALID ≥3 cycles across all scenarios.
